// File: rtl/fifo_rst_sched.sv
// Reset scheduler for the readout FIFO bank: gathers reset requests, batches them and
// runs quiesce -> reset pulse -> settle -> acknowledge, starting with a power-up pass.
module fifo_rst_sched #(
    parameter int NREQ       = 4,
    parameter int QUIET_CYC  = 4,
    parameter int RST_CYC    = 10,
    parameter int SETTLE_CYC = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] ACK,
    output logic [NREQ-1:0] SERVING,
    output logic            FIFO_RST,
    output logic            FIFO_EN,
    output logic            BUSY,
    output logic            READY,
    output logic [2:0]      DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_QUIET  = 3'd1,
        S_ASSERT = 3'd2,
        S_SETTLE = 3'd3,
        S_ACKS   = 3'd4
    } state_t;

    localparam logic [7:0] QUIET_LAST  = 8'(QUIET_CYC - 1);
    localparam logic [7:0] RST_LAST    = 8'(RST_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_t          state;
    state_t          state_nx;
    logic [7:0]      count;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] snapshot;
    logic [NREQ-1:0] snapshot_nx;
    logic            take;

    assign DBG_STATE = state;

    always_comb begin
        state_nx    = state;
        snapshot_nx = snapshot;
        take        = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    take        = 1'b1;
                    snapshot_nx = pending;
                    state_nx    = S_QUIET;
                end
            end
            S_QUIET: begin
                if (count == QUIET_LAST) state_nx = S_ASSERT;
            end
            S_ASSERT: begin
                if (count == RST_LAST) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (count == SETTLE_LAST) state_nx = S_ACKS;
            end
            S_ACKS: begin
                // Requests that arrived during the sequence start the next batch without re-enabling the FIFOs.
                if (|pending) begin
                    take        = 1'b1;
                    snapshot_nx = pending;
                    state_nx    = S_QUIET;
                end else begin
                    snapshot_nx = '0;
                    state_nx    = S_IDLE;
                end
            end
            default: begin
                state_nx    = S_ASSERT;
                snapshot_nx = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_ASSERT;
            count    <= 8'd0;
            pending  <= '0;
            snapshot <= '0;
            FIFO_RST <= 1'b1;
            FIFO_EN  <= 1'b0;
            BUSY     <= 1'b1;
            READY    <= 1'b0;
            ACK      <= '0;
            SERVING  <= '0;
        end else begin
            state    <= state_nx;
            count    <= (state_nx != state) ? 8'd0 : count + 8'd1;
            pending  <= (pending & ~(take ? snapshot_nx : '0)) | REQ;
            snapshot <= snapshot_nx;
            FIFO_RST <= (state_nx == S_ASSERT);
            FIFO_EN  <= (state_nx == S_IDLE);
            BUSY     <= (state_nx != S_IDLE);
            READY    <= READY | (state == S_ACKS);
            ACK      <= (state_nx == S_ACKS) ? snapshot_nx : '0;
            SERVING  <= snapshot_nx;
        end
    end

endmodule

// File: tb/tb_fifo_rst_sched.sv
// Bench for fifo_rst_sched: timeline tables from the documented latencies, directed
// corner sequences, and randomized traffic against a sequence-position reference model.
module tb_fifo_rst_sched;

    localparam int NREQ = 4;
    localparam int Q    = 4;
    localparam int R    = 10;
    localparam int S    = 15;
    localparam int L    = Q + R + S;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] ACK, SERVING;
    logic            FIFO_RST, FIFO_EN, BUSY, READY;
    logic [2:0]      dbg;

    logic [NREQ-1:0] req2;
    logic [NREQ-1:0] m_ack, m_serving;
    logic            m_rst, m_en, m_busy, m_ready;
    logic [2:0]      m_dbg;

    fifo_rst_sched #(.NREQ(NREQ), .QUIET_CYC(Q), .RST_CYC(R), .SETTLE_CYC(S)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ACK(ACK), .SERVING(SERVING),
        .FIFO_RST(FIFO_RST), .FIFO_EN(FIFO_EN), .BUSY(BUSY), .READY(READY),
        .DBG_STATE(dbg)
    );

    fifo_rst_sched #(.NREQ(NREQ), .QUIET_CYC(1), .RST_CYC(1), .SETTLE_CYC(1)) dut_min (
        .CLK(CLK), .RST(RST), .REQ(req2), .ACK(m_ack), .SERVING(m_serving),
        .FIFO_RST(m_rst), .FIFO_EN(m_en), .BUSY(m_busy), .READY(m_ready),
        .DBG_STATE(m_dbg)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: position within a batch timeline (quiet, pulse, settle, ack at L).
    bit              m_active;
    int              m_t;
    logic [NREQ-1:0] m_snap, m_pend;
    bit              m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b1;
        m_t      = Q;
        m_snap   = '0;
        m_pend   = '0;
        m_rdy    = 1'b0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] req);
        if (m_active) begin
            if (m_t == L) begin
                m_rdy = 1'b1;
                if (m_pend != 0) begin
                    m_t    = 0;
                    m_snap = m_pend;
                    m_pend = '0;
                end else begin
                    m_active = 1'b0;
                    m_snap   = '0;
                end
            end else begin
                m_t++;
            end
        end else if (m_pend != 0) begin
            m_active = 1'b1;
            m_t      = 0;
            m_snap   = m_pend;
            m_pend   = '0;
        end
        m_pend = m_pend | req;
    endtask

    task automatic check_model();
        logic [NREQ-1:0] e_ack, e_srv;
        logic            e_rst, e_en, e_busy;
        if (m_active) begin
            e_en   = 1'b0;
            e_busy = 1'b1;
            e_rst  = (m_t >= Q) && (m_t < Q + R);
            e_ack  = (m_t == L) ? m_snap : '0;
            e_srv  = m_snap;
        end else begin
            e_en   = 1'b1;
            e_busy = 1'b0;
            e_rst  = 1'b0;
            e_ack  = '0;
            e_srv  = '0;
        end
        check("model_ack",      32'(ACK),      32'(e_ack));
        check("model_serving",  32'(SERVING),  32'(e_srv));
        check("model_fifo_rst", 32'(FIFO_RST), 32'(e_rst));
        check("model_fifo_en",  32'(FIFO_EN),  32'(e_en));
        check("model_busy",     32'(BUSY),     32'(e_busy));
        check("model_ready",    32'(READY),    32'(m_rdy));
        check("en_rst_exclusive", 32'(FIFO_EN & FIFO_RST), 32'(0));
    endtask

    task automatic step();
        @(posedge CLK);
        if (!RST) model_edge(REQ);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        REQ  = '0;
        req2 = '0;
        model_reset();
        #1;
        check("rst_fifo_rst", 32'(FIFO_RST), 32'(1));
        check("rst_fifo_en",  32'(FIFO_EN),  32'(0));
        check("rst_busy",     32'(BUSY),     32'(1));
        check("rst_ready",    32'(READY),    32'(0));
        check("rst_ack",      32'(ACK),      32'(0));
        check("rst_serving",  32'(SERVING),  32'(0));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        int   off;
        logic en;
        logic rst;
        logic ack_on;
        logic srv_on;
        logic busy;
    } row_t;

    row_t            rows[8];
    logic [NREQ-1:0] pats[4];
    int              k;

    initial begin
        rows[0] = '{off: 1,  en: 0, rst: 0, ack_on: 0, srv_on: 1, busy: 1};
        rows[1] = '{off: 4,  en: 0, rst: 0, ack_on: 0, srv_on: 1, busy: 1};
        rows[2] = '{off: 5,  en: 0, rst: 1, ack_on: 0, srv_on: 1, busy: 1};
        rows[3] = '{off: 14, en: 0, rst: 1, ack_on: 0, srv_on: 1, busy: 1};
        rows[4] = '{off: 15, en: 0, rst: 0, ack_on: 0, srv_on: 1, busy: 1};
        rows[5] = '{off: 29, en: 0, rst: 0, ack_on: 0, srv_on: 1, busy: 1};
        rows[6] = '{off: 30, en: 0, rst: 0, ack_on: 1, srv_on: 1, busy: 1};
        rows[7] = '{off: 31, en: 1, rst: 0, ack_on: 0, srv_on: 0, busy: 0};
        pats[0] = 4'b0100;
        pats[1] = 4'b0001;
        pats[2] = 4'b1010;
        pats[3] = 4'b1111;

        // Power-up pass
        do_reset();
        for (int i = 0; i < 27; i++) begin
            step();
            check("pu_fifo_rst", 32'(FIFO_RST), 32'(cyc < R));
            check("pu_ack",      32'(ACK),      32'(0));
            check("pu_ready",    32'(READY),    32'(cyc >= R + S + 1));
            check("pu_fifo_en",  32'(FIFO_EN),  32'(cyc >= R + S + 1));
            check("pu_busy",     32'(BUSY),     32'(cyc < R + S + 1));
        end

        // Single-request timeline for several requester patterns
        for (int p = 0; p < 4; p++) begin
            REQ = pats[p];
            step();
            REQ = '0;
            k = cyc;
            for (int r = 0; r < 8; r++) begin
                run_to(k + rows[r].off);
                check("tbl_fifo_en",  32'(FIFO_EN),  32'(rows[r].en));
                check("tbl_fifo_rst", 32'(FIFO_RST), 32'(rows[r].rst));
                check("tbl_busy",     32'(BUSY),     32'(rows[r].busy));
                check("tbl_ack",      32'(ACK),      32'(rows[r].ack_on ? pats[p] : 4'b0000));
                check("tbl_serving",  32'(SERVING),  32'(rows[r].srv_on ? pats[p] : 4'b0000));
            end
        end

        // Coalescing: late request rides the next back-to-back batch
        REQ = 4'b0001;
        step();
        k = cyc;
        REQ = 4'b1000;
        step();
        REQ = '0;
        run_to(k + 30);
        check("coal_ack1", 32'(ACK), 32'(4'b0001));
        run_to(k + 31);
        check("coal_en_low",  32'(FIFO_EN), 32'(0));
        check("coal_serving", 32'(SERVING), 32'(4'b1000));
        run_to(k + 60);
        check("coal_ack2", 32'(ACK), 32'(4'b1000));
        run_to(k + 61);
        check("coal_en_high", 32'(FIFO_EN), 32'(1));

        // Re-request during own pulse
        REQ = 4'b0010;
        step();
        k = cyc;
        REQ = '0;
        run_to(k + 7);
        REQ = 4'b0010;
        step();
        REQ = '0;
        run_to(k + 30);
        check("rereq_ack1", 32'(ACK), 32'(4'b0010));
        run_to(k + 31);
        check("rereq_en_low", 32'(FIFO_EN), 32'(0));
        check("rereq_ack_gap", 32'(ACK), 32'(0));
        run_to(k + 60);
        check("rereq_ack2", 32'(ACK), 32'(4'b0010));
        run_to(k + 61);
        check("rereq_en_high", 32'(FIFO_EN), 32'(1));

        // Reset while settling with bit 2 pending: the request is dropped
        REQ = 4'b0001;
        step();
        k = cyc;
        REQ = '0;
        run_to(k + 19);
        REQ = 4'b0100;
        step();
        REQ = '0;
        do_reset();
        for (int i = 0; i < 35; i++) begin
            step();
            check("midrst_ack", 32'(ACK), 32'(0));
            check("midrst_serving", 32'(SERVING), 32'(0));
        end
        check("midrst_idle_en", 32'(FIFO_EN), 32'(1));
        check("midrst_ready", 32'(READY), 32'(1));

        // Minimum timing instance
        check("min_idle_en", 32'(m_en), 32'(1));
        req2 = 4'b0100;
        step();
        req2 = '0;
        k = cyc;
        for (int o = 1; o <= 5; o++) begin
            run_to(k + o);
            check("min_fifo_rst", 32'(m_rst), 32'(o == 2));
            check("min_ack",      32'(m_ack), 32'((o == 4) ? 4'b0100 : 4'b0000));
            check("min_fifo_en",  32'(m_en),  32'(o == 5));
            check("min_busy",     32'(m_busy), 32'(o != 5));
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            REQ = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step();
        end
        REQ = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rst_sched.md
# fifo_rst_sched

Reset scheduler for the DCFEB readout FIFOs: collects FIFO-reset requests from up to NREQ sources (power-up, run start, overflow recovery, slow-control command), coalesces them, and runs one sequence per batch: quiesce → reset pulse → settle → acknowledge. It owns the FIFO_RST and FIFO_EN lines of the FIFO bank. It also performs an automatic power-up reset after RST, so no separate power-up reset FSM is needed.

## Interface
- NREQ, 4, number of request sources (1..8)
- QUIET_CYC, 4, cycles FIFO_EN is low before the reset pulse (1..256)
- RST_CYC, 10, FIFO_RST pulse length in cycles (1..256)
- SETTLE_CYC, 15, cycles after the pulse before acknowledge (1..256)

Ports:
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  asynchronous, active-high block reset
- REQ  input  NREQ  per-source reset request; sampled each edge, any high sample registers a request
- ACK  output  NREQ  one-cycle pulse; bits = requesters served by the completed sequence
- SERVING  output  NREQ  snapshot of requesters in the current sequence; 0 when IDLE
- FIFO_RST  output  1  reset to FIFO bank
- FIFO_EN  output  1  read/write enable to FIFO bank; high only in IDLE
- BUSY  output  1  high whenever state ≠ IDLE
- READY  output  1  sticky; high once the power-up sequence completes

## Operation
- States: IDLE, QUIET, ASSERT, SETTLE, ACKS. One 8-bit counter, cleared on every state change.
- All outputs registered and decoded from the next state, so they change on the same edge as the state.
- Reset values: state=ASSERT, count=0, pending=0, snapshot=0. Outputs: FIFO_RST=1, FIFO_EN=0, BUSY=1, READY=0, ACK=0, SERVING=0.
- pending register: each edge, pending |= REQ. When a snapshot is taken, the snapshotted bits are cleared, but REQ bits sampled on that same edge remain set.
- IDLE:
  - if pending≠0, then snapshot←pending and go to QUIET.
  - else stay in IDLE.
- QUIET: FIFO_EN=0 and FIFO_RST=0. After QUIET_CYC cycles, go to ASSERT.
- ASSERT: FIFO_RST=1. After RST_CYC cycles (exit when count==RST_CYC-1), go to SETTLE.
- SETTLE: FIFO_RST=0 and FIFO_EN=0. After SETTLE_CYC cycles, go to ACKS.
- ACKS lasts one cycle:
  - ACK=snapshot and READY←1.
  - if pending≠0, go straight to QUIET with a new snapshot; FIFO_EN stays low.
  - else go to IDLE and clear snapshot.
- Power-up sequence: starts in ASSERT with snapshot=0. It produces ACKS with ACK=0 and sets READY.
- A request for a source already in the current snapshot is held in pending and serviced by the next sequence; no merging into the running sequence.
- Multiple sources pending at the snapshot are served by one sequence; all their ACK bits pulse together.
- RST mid-sequence: abandons the sequence and clears pending, so those requests are lost and not acknowledged. Power-up sequence restarts.
- Unused/X states recover to ASSERT with snapshot=0.

## Timing
Edges are numbered from the first rising edge after RST deasserts (edge 1), or from the edge that samples REQ (edge k).

- Power-up:
  - FIFO_RST high for exactly RST_CYC cycles after RST release; low from edge RST_CYC.
  - ACKS at edge RST_CYC+SETTLE_CYC.
  - IDLE, FIFO_EN=1, READY=1, BUSY=0 at edge RST_CYC+SETTLE_CYC+1.
- Request latency, for a request sampled at edge k while idle:
  - QUIET, FIFO_EN=0, BUSY=1 at edge k+1.
  - FIFO_RST=1 at edge k+1+QUIET_CYC.
  - FIFO_RST=0 at edge k+1+QUIET_CYC+RST_CYC.
  - ACK at edge k+1+QUIET_CYC+RST_CYC+SETTLE_CYC.
  - FIFO_EN=1 one edge later.
- FIFO_EN and FIFO_RST are never both high. FIFO_EN falls at least QUIET_CYC cycles before FIFO_RST rises (except at power-up).
- ACK is never high for more than one consecutive cycle per sequence.

## Test plan
- Power-up, defaults:
  - RST released → FIFO_RST high for 10 cycles, ACK stays 0.
  - READY and FIFO_EN rise at edge 26; BUSY falls at edge 26.
- Single request: REQ=4'b0100 for one cycle at edge k →
  - FIFO_EN low at k+1
  - FIFO_RST high for edges k+5..k+14
  - ACK=4'b0100 for one cycle at k+30
  - FIFO_EN high at k+31
- Coalescing: REQ[0] at edge k, REQ[3] at edge k+1 →
  - first sequence ACK=4'b0001 at k+30.
  - ACKS goes directly to QUIET (FIFO_EN stays low).
  - second ACK=4'b1000 at k+60.
- Re-request: REQ[1] again during ASSERT of its own sequence → ACK=4'b0010 twice, in two separate back-to-back sequences.
- Reset mid-operation:
  - RST pulsed during SETTLE with REQ[2] pending → all outputs at reset values.
  - Power-up sequence reruns; ACK never asserts for bit 2.
- Minimum parameters QUIET_CYC=RST_CYC=SETTLE_CYC=1: request at k → FIFO_RST high only at k+2, ACK at k+4, FIFO_EN high at k+5.
